fault_target_array: RTL and testbench
=====================================

# fault_target_array

Parametrised laser fault-injection target: a DEPTH×N array of attackable registers plus a golden copy, compared every cycle. Mismatches are reported three ways: a raw per-bit vector, a per-bit debounced vector suitable for LEDs, and a sticky first-fault capture with a saturating fault-cycle counter. It sits behind the board clock wizard, fed by the 100 MHz `clk`. Synthesis must keep equivalent registers so the target words and the golden copy are not merged.

## Interface
- `N`, 8: bits per target word.
- `DEPTH`, 4: number of target words (≥2).
- `AW`, 2: word-index width, equal to clog2(DEPTH).
- `DB_COUNT_MAX`, 2000: debounce threshold in clk cycles.
- `DB_COUNT_N`, 15: debounce counter width (must hold DB_COUNT_MAX).
- `CNT_W`, 16: fault-cycle counter width.

Ports:
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `load` in 1: writes `pattern` into every target word and the golden word; disarms.
- `pattern` in N: load value.
- `arm` in 1: starts comparison.
- `clear` in 1: clears capture and counter.
- `mode` in 1: 0 = hold, 1 = toggle.
- `armed` out 1: comparison active.
- `fault_raw` out N: registered OR over words of (target ^ golden).
- `fault_db` out N: debounced `fault_raw`.
- `led` out N: equals `fault_db`.
- `fault_valid` out 1: sticky, set when a first fault is captured.
- `fault_word` out AW: index of the first faulted word.
- `fault_mask` out N: XOR mask of that word at capture.
- `fault_count` out CNT_W: cycles with nonzero mismatch, saturating.

## Operation
- **Reset (reset_n=0):** every register and output goes to 0, including target, golden, armed, and the debounce counters.
- **load:** target[k] ← pattern and golden ← pattern for all k; armed ← 0. If `load` and `arm` are both high, load wins and armed stays 0.
- **arm (with load=0):** armed ← 1. Armed stays 1 until `load` or reset.
- **Toggle mode (mode=1, armed=1):** every target word and golden invert each cycle. In hold mode, or when unarmed, they are static.
- **Compare (armed=1):** mism[k] = target[k] ^ golden, evaluated on current register values. fault_raw ← OR_k mism[k]. When unarmed, fault_raw ← 0.
- **Debounce, per bit i:**
  - If fault_raw[i] == fault_db[i], cnt[i] ← 0; otherwise cnt[i] ← cnt[i]+1.
  - fault_db[i] ← fault_raw[i] when cnt[i] ≥ DB_COUNT_MAX.
- **Capture:** on a cycle where fault_raw ≠ 0 and fault_valid = 0:
  - fault_valid ← 1.
  - fault_word ← lowest k with mism[k] ≠ 0, registered alongside fault_raw.
  - fault_mask ← that word's mism.
  - While fault_valid = 1, these outputs hold.
- **Counter:** fault_count increments each cycle fault_raw ≠ 0 and saturates at 2^CNT_W−1.
- **clear:** zeroes fault_valid, fault_word, fault_mask and fault_count. It does not affect fault_db, the debounce counters, target or armed. If clear and a new capture condition occur in the same cycle, clear wins; capture happens on a later cycle.

## Timing
- load at edge t: target/golden updated at t. A fault injected into target at cycle u appears on fault_raw at edge u+1.
- fault_valid, fault_word, fault_mask and the first count increment appear at edge u+2, one cycle after fault_raw.
- fault_db follows fault_raw after DB_COUNT_MAX+1 consecutive differing cycles. A transient shorter than that never reaches fault_db.
- In toggle mode, target and golden flip on the same edge, so the mismatch is invariant under toggling.
- Asynchronous reset mid-operation clears everything immediately, with no partial capture.

## Test plan
Parameters for all cases: N=8, DEPTH=4, DB_COUNT_MAX=4, CNT_W=4.

1. **Load then arm:** pattern=0xA5, load, then arm. Response: armed=1, fault_raw=0x00 for 20 cycles, fault_valid=0, fault_count=0.
2. **Injected fault:** force target[2] bit 3 flipped (0xAD) for the remainder of the run. Response:
   - fault_raw=0x08 one cycle later.
   - fault_valid=1, fault_word=2, fault_mask=0x08 the next cycle.
   - fault_db=0x08 after 5 further cycles.
   - fault_count saturates at 15.
3. **Short transient:** flip target[0] bit 0 for 2 cycles, then restore by load 0xA5 + arm. Response: fault_raw pulses 0x01, fault_db stays 0x00, fault_valid=1, fault_word=0.
4. **Simultaneous faults:** faults in words 1 (0x10) and 3 (0x01) in the same cycle. Response: fault_raw=0x11, fault_word=1, fault_mask=0x10.
5. **Toggle mode:** mode=1, pattern=0x0F, fault flips target[1] bit 7 once. Response: fault_raw=0x80 persistent while golden/targets alternate 0x0F/0xF0.
6. **clear, clear+capture, and reset:**
   - clear with a fault still present: fault_valid=0 and count=0 for one cycle, then recapture.
   - clear asserted together with a new capture condition: clear wins, capture occurs the following cycle.
   - reset_n pulsed low mid-run: all outputs 0 asynchronously.

Source files
------------

// File: rtl/fault_target_array_if.sv
// Control and observation bundle for the fault-injection target array.
// The master side drives load/arm/clear/mode and watches the fault reports;
// the slave side is the target array itself.
interface fault_target_array_if #(
   parameter int N     = 8,
   parameter int AW    = 2,
   parameter int CNT_W = 16
);
   logic             load;
   logic [N-1:0]     pattern;
   logic             arm;
   logic             clear;
   logic             mode;

   logic             armed;
   logic [N-1:0]     fault_raw;
   logic [N-1:0]     fault_db;
   logic [N-1:0]     led;
   logic             fault_valid;
   logic [AW-1:0]    fault_word;
   logic [N-1:0]     fault_mask;
   logic [CNT_W-1:0] fault_count;

   modport master (
      output load, pattern, arm, clear, mode,
      input  armed, fault_raw, fault_db, led, fault_valid, fault_word, fault_mask, fault_count
   );

   modport slave (
      input  load, pattern, arm, clear, mode,
      output armed, fault_raw, fault_db, led, fault_valid, fault_word, fault_mask, fault_count
   );
endinterface

// File: rtl/fault_target_array.sv
// Laser fault-injection target: DEPTH attackable words plus a golden word,
// compared every cycle. Reports a raw mismatch vector, a debounced copy for
// LEDs, and a sticky first-fault capture with a saturating fault-cycle count.
// The target words and golden word are logically identical by construction,
// so they carry keep attributes to stop synthesis from merging them.
module fault_target_array #(
   parameter int N            = 8,
   parameter int DEPTH        = 4,
   parameter int AW           = 2,
   parameter int DB_COUNT_MAX = 2000,
   parameter int DB_COUNT_N   = 15,
   parameter int CNT_W        = 16
) (
   input logic                 clk,
   input logic                 reset_n,
   fault_target_array_if.slave bus
);
   localparam logic [DB_COUNT_N-1:0] DB_LIMIT = DB_COUNT_N'(DB_COUNT_MAX);
   localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};

   (* keep = "true" *) logic [DEPTH-1:0][N-1:0] target;
   (* keep = "true" *) logic [N-1:0]            golden;

   logic                  armed;
   logic [N-1:0]          fault_raw;
   logic [AW-1:0]         pend_word;
   logic [N-1:0]          pend_mask;
   logic [N-1:0]          fault_db;
   logic [DB_COUNT_N-1:0] db_cnt [N];
   logic                  fault_valid;
   logic [AW-1:0]         fault_word;
   logic [N-1:0]          fault_mask;
   logic [CNT_W-1:0]      fault_count;

   logic [N-1:0]          mism_or;
   logic [AW-1:0]         first_word;
   logic [N-1:0]          first_mask;
   logic                  found;

   // OR of all word mismatches, plus the lowest-indexed faulted word and its mask
   always_comb begin
      mism_or    = '0;
      first_word = '0;
      first_mask = '0;
      found      = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         mism_or = mism_or | (target[k] ^ golden);
         if (!found && ((target[k] ^ golden) != '0)) begin
            found      = 1'b1;
            first_word = AW'(k);
            first_mask = target[k] ^ golden;
         end
      end
   end

   // Target/golden storage: load wins over arm; toggle mode inverts both together
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         target <= '0;
         golden <= '0;
         armed  <= 1'b0;
      end else if (bus.load) begin
         for (int k = 0; k < DEPTH; k++) target[k] <= bus.pattern;
         golden <= bus.pattern;
         armed  <= 1'b0;
      end else begin
         if (armed && bus.mode) begin
            target <= ~target;
            golden <= ~golden;
         end
         if (bus.arm) armed <= 1'b1;
      end
   end

   // Registered compare; first-word info is staged alongside fault_raw for capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fault_raw <= '0;
         pend_word <= '0;
         pend_mask <= '0;
      end else if (armed) begin
         fault_raw <= mism_or;
         pend_word <= first_word;
         pend_mask <= first_mask;
      end else begin
         fault_raw <= '0;
         pend_word <= '0;
         pend_mask <= '0;
      end
   end

   // Per-bit debounce: fault_db adopts fault_raw after DB_COUNT_MAX+1 differing cycles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fault_db <= '0;
         for (int i = 0; i < N; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (fault_raw[i] == fault_db[i]) db_cnt[i] <= '0;
            else                             db_cnt[i] <= db_cnt[i] + DB_COUNT_N'(1);
            if (db_cnt[i] >= DB_LIMIT) fault_db[i] <= fault_raw[i];
         end
      end
   end

   // Sticky first-fault capture and saturating fault-cycle counter; clear has priority
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fault_valid <= 1'b0;
         fault_word  <= '0;
         fault_mask  <= '0;
         fault_count <= '0;
      end else if (bus.clear) begin
         fault_valid <= 1'b0;
         fault_word  <= '0;
         fault_mask  <= '0;
         fault_count <= '0;
      end else begin
         if ((fault_raw != '0) && !fault_valid) begin
            fault_valid <= 1'b1;
            fault_word  <= pend_word;
            fault_mask  <= pend_mask;
         end
         if ((fault_raw != '0) && (fault_count != CNT_MAX))
            fault_count <= fault_count + CNT_W'(1);
      end
   end

   assign bus.armed       = armed;
   assign bus.fault_raw   = fault_raw;
   assign bus.fault_db    = fault_db;
   assign bus.led         = fault_db;
   assign bus.fault_valid = fault_valid;
   assign bus.fault_word  = fault_word;
   assign bus.fault_mask  = fault_mask;
   assign bus.fault_count = fault_count;
endmodule

// File: tb/tb_fault_target_array.sv
// Bench for fault_target_array. Faults are injected by forcing the internal
// target register; a behavioural model tracks the un-faulted contents and the
// injected XOR masks and predicts every output each cycle.
module tb_fault_target_array;
   localparam int N       = 8;
   localparam int DEPTH   = 4;
   localparam int AW      = 2;
   localparam int DBMAX   = 4;
   localparam int DBN     = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk;
   logic reset_n;

   fault_target_array_if #(.N(N), .AW(AW), .CNT_W(CNT_W)) bus ();

   fault_target_array #(
      .N(N), .DEPTH(DEPTH), .AW(AW),
      .DB_COUNT_MAX(DBMAX), .DB_COUNT_N(DBN), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;
   bit cmp_en     = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [N-1:0]  inj [DEPTH];
   logic [N-1:0]  m_nat [DEPTH];
   logic [N-1:0]  m_gold;
   bit            m_armed;
   logic [N-1:0]  m_raw;
   logic [AW-1:0] m_pword;
   logic [N-1:0]  m_pmask;
   logic [N-1:0]  m_db;
   int            streak [N];
   bit            m_valid;
   logic [AW-1:0] m_word;
   logic [N-1:0]  m_mask;
   int            m_count;

   initial forever begin : model
      logic [N-1:0]  e, nr, fm;
      logic [AW-1:0] fw;
      bit            found, tog;
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) m_nat[k] = '0;
         m_gold = '0; m_armed = 0; m_raw = '0; m_pword = '0; m_pmask = '0;
         m_db = '0; m_valid = 0; m_word = '0; m_mask = '0; m_count = 0;
         for (int i = 0; i < N; i++) streak[i] = 0;
      end else begin
         nr = '0; fw = '0; fm = '0; found = 0;
         if (m_armed) begin
            for (int k = 0; k < DEPTH; k++) begin
               e  = m_nat[k] ^ inj[k] ^ m_gold;
               nr = nr | e;
               if (!found && e != '0) begin
                  found = 1; fw = AW'(k); fm = e;
               end
            end
         end
         // LED bit takes the raw value once it has disagreed for DBMAX+1 samples in a row
         for (int i = 0; i < N; i++) begin
            if (m_raw[i] != m_db[i]) begin
               streak[i] = streak[i] + 1;
               if (streak[i] > DBMAX) m_db[i] = m_raw[i];
            end else begin
               streak[i] = 0;
            end
         end
         if (bus.clear) begin
            m_valid = 0; m_word = '0; m_mask = '0; m_count = 0;
         end else begin
            if (m_raw != '0 && !m_valid) begin
               m_valid = 1; m_word = m_pword; m_mask = m_pmask;
            end
            if (m_raw != '0 && m_count < CNT_MAX) m_count = m_count + 1;
         end
         m_raw = nr; m_pword = fw; m_pmask = fm;
         tog = m_armed && bus.mode && !bus.load;
         if (bus.load) begin
            for (int k = 0; k < DEPTH; k++) m_nat[k] = bus.pattern;
            m_gold = bus.pattern; m_armed = 0;
         end else begin
            if (bus.arm) m_armed = 1;
            if (tog) begin
               for (int k = 0; k < DEPTH; k++) m_nat[k] = ~m_nat[k];
               m_gold = ~m_gold;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin : compare
      @(negedge clk);
      if (cmp_en) begin
         chk("armed",       32'(bus.armed),       32'(m_armed));
         chk("fault_raw",   32'(bus.fault_raw),   32'(m_raw));
         chk("fault_db",    32'(bus.fault_db),    32'(m_db));
         chk("led",         32'(bus.led),         32'(m_db));
         chk("fault_valid", 32'(bus.fault_valid), 32'(m_valid));
         chk("fault_word",  32'(bus.fault_word),  32'(m_word));
         chk("fault_mask",  32'(bus.fault_mask),  32'(m_mask));
         chk("fault_count", 32'(bus.fault_count), 32'(m_count));
      end
   end

   // ---------------- fault injection ----------------
   logic [DEPTH-1:0][N-1:0] force_val;
   bit forced = 0;

   task automatic apply_force();
      bit any;
      any = 0;
      for (int k = 0; k < DEPTH; k++) begin
         force_val[k] = m_nat[k] ^ inj[k];
         if (inj[k] != '0) any = 1;
      end
      if (any) begin
         force dut.target = force_val;
         forced = 1;
      end else if (forced) begin
         force dut.target = force_val;
         release dut.target;
         forced = 0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      apply_force();
   endtask

   task automatic do_reset();
      #2;
      for (int k = 0; k < DEPTH; k++) inj[k] = '0;
      apply_force();
      bus.load = 0; bus.arm = 0; bus.clear = 0; bus.mode = 0; bus.pattern = '0;
      reset_n = 0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1;
   endtask

   task automatic load_arm(input logic [N-1:0] p, input logic md);
      bus.mode = md; bus.pattern = p; bus.load = 1;
      tick();
      bus.load = 0; bus.arm = 1;
      tick();
      bus.arm = 0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- directed stimulus ----------------
   initial begin : stim
      for (int k = 0; k < DEPTH; k++) inj[k] = '0;
      bus.load = 0; bus.arm = 0; bus.clear = 0; bus.mode = 0; bus.pattern = '0;
      reset_n = 0;
      repeat (2) @(negedge clk);
      chk("reset_armed", 32'(bus.armed), 32'h0);
      chk("reset_count", 32'(bus.fault_count), 32'h0);
      reset_n = 1;
      cmp_en  = 1;

      // load and arm together: load wins
      bus.pattern = 8'hA5; bus.load = 1; bus.arm = 1;
      tick();
      chk("load_beats_arm", 32'(bus.armed), 32'h0);
      bus.load = 0;
      tick();
      bus.arm = 0;
      chk("arm_sets", 32'(bus.armed), 32'h1);
      repeat (20) tick();
      chk("idle_raw", 32'(bus.fault_raw), 32'h0);
      chk("idle_valid", 32'(bus.fault_valid), 32'h0);

      // persistent fault on word 2, bit 3
      do_reset();
      load_arm(8'hA5, 1'b0);
      inj[2] = 8'h08; apply_force();
      tick();
      chk("t2_raw", 32'(bus.fault_raw), 32'h08);
      chk("t2_valid_late", 32'(bus.fault_valid), 32'h0);
      tick();
      chk("t2_valid", 32'(bus.fault_valid), 32'h1);
      chk("t2_word", 32'(bus.fault_word), 32'h2);
      chk("t2_mask", 32'(bus.fault_mask), 32'h08);
      chk("t2_count1", 32'(bus.fault_count), 32'h1);
      repeat (3) tick();
      chk("t2_db_early", 32'(bus.fault_db), 32'h00);
      tick();
      chk("t2_db", 32'(bus.fault_db), 32'h08);
      repeat (15) tick();
      chk("t2_count_sat", 32'(bus.fault_count), 32'hF);

      // two-cycle transient on word 0 bit 0, restored by reload
      do_reset();
      load_arm(8'hA5, 1'b0);
      inj[0] = 8'h01; apply_force();
      tick();
      chk("t3_raw", 32'(bus.fault_raw), 32'h01);
      tick();
      inj[0] = 8'h00; apply_force();
      bus.pattern = 8'hA5; bus.load = 1;
      tick();
      bus.load = 0; bus.arm = 1;
      tick();
      bus.arm = 0;
      repeat (10) tick();
      chk("t3_db", 32'(bus.fault_db), 32'h00);
      chk("t3_valid", 32'(bus.fault_valid), 32'h1);
      chk("t3_word", 32'(bus.fault_word), 32'h0);
      chk("t3_count", 32'(bus.fault_count), 32'h2);

      // simultaneous faults in words 1 and 3
      do_reset();
      load_arm(8'hA5, 1'b0);
      inj[1] = 8'h10; inj[3] = 8'h01; apply_force();
      tick();
      chk("t4_raw", 32'(bus.fault_raw), 32'h11);
      tick();
      chk("t4_word", 32'(bus.fault_word), 32'h1);
      chk("t4_mask", 32'(bus.fault_mask), 32'h10);

      // toggle mode with word 1 bit 7 flipped
      do_reset();
      load_arm(8'h0F, 1'b1);
      chk("t5_gold0", 32'(dut.golden), 32'h0F);
      inj[1] = 8'h80; apply_force();
      tick();
      chk("t5_raw_a", 32'(bus.fault_raw), 32'h80);
      chk("t5_gold_a", 32'(dut.golden), 32'hF0);
      chk("t5_tgt_a", 32'(dut.target[1]), 32'h70);
      tick();
      chk("t5_raw_b", 32'(bus.fault_raw), 32'h80);
      chk("t5_gold_b", 32'(dut.golden), 32'h0F);
      chk("t5_tgt_b", 32'(dut.target[1]), 32'h8F);
      repeat (6) tick();
      chk("t5_raw_c", 32'(bus.fault_raw), 32'h80);

      // clear with the fault still present, then recapture
      do_reset();
      load_arm(8'hA5, 1'b0);
      inj[2] = 8'h08; apply_force();
      repeat (4) tick();
      bus.clear = 1;
      tick();
      bus.clear = 0;
      chk("t6_clr_valid", 32'(bus.fault_valid), 32'h0);
      chk("t6_clr_count", 32'(bus.fault_count), 32'h0);
      tick();
      chk("t6_recap_valid", 32'(bus.fault_valid), 32'h1);
      chk("t6_recap_count", 32'(bus.fault_count), 32'h1);

      // clear on the very cycle a first capture would happen
      do_reset();
      load_arm(8'hA5, 1'b0);
      inj[2] = 8'h08; apply_force();
      tick();
      bus.clear = 1;
      tick();
      bus.clear = 0;
      chk("t6b_valid", 32'(bus.fault_valid), 32'h0);
      chk("t6b_count", 32'(bus.fault_count), 32'h0);
      tick();
      chk("t6b_valid2", 32'(bus.fault_valid), 32'h1);
      chk("t6b_word", 32'(bus.fault_word), 32'h2);
      chk("t6b_mask", 32'(bus.fault_mask), 32'h08);
      repeat (4) tick();
      chk("t6b_db", 32'(bus.fault_db), 32'h08);

      // asynchronous reset mid-cycle
      #2;
      for (int k = 0; k < DEPTH; k++) inj[k] = '0;
      apply_force();
      reset_n = 0;
      #1;
      chk("rst_armed", 32'(bus.armed), 32'h0);
      chk("rst_raw", 32'(bus.fault_raw), 32'h0);
      chk("rst_db", 32'(bus.fault_db), 32'h0);
      chk("rst_valid", 32'(bus.fault_valid), 32'h0);
      chk("rst_mask", 32'(bus.fault_mask), 32'h0);
      chk("rst_count", 32'(bus.fault_count), 32'h0);
      chk("rst_target", 32'(dut.target), 32'h0);
      chk("rst_golden", 32'(dut.golden), 32'h0);
      @(negedge clk);
      reset_n = 1;
      repeat (3) tick();

      cmp_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
